// File: rtl/lsu_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : lsu_arbiter_if
// Description : Request/grant/read-data bundle between one lsu master and the
//               lsu_arbiter. The master drives the request payload; the
//               arbiter answers with grant and read-data pulses.
// Revision    : 1.0 - initial release
// ============================================================================
interface lsu_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 32
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [2:0]    mode;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  // Requester side: owns the payload, observes grant and returned data.
  modport master (
    output req, we, addr, wdata, mode,
    input  gnt, rvalid, rdata
  );

  // Arbiter side: samples the payload, answers with grant and read data.
  modport slave (
    input  req, we, addr, wdata, mode,
    output gnt, rvalid, rdata
  );
endinterface
`default_nettype wire

// File: rtl/lsu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : lsu_arbiter
// Description : Round-robin arbiter and sequencer for two masters sharing a
//               single-ported lsu. One access in flight at a time; read data
//               is returned to the winning master with a one-cycle valid.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_arbiter #(
  parameter int AW     = 16,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  lsu_arbiter_if.slave   m0,
  lsu_arbiter_if.slave   m1,
  output logic           lsu_w_en,
  output logic [AW-1:0]  lsu_addr,
  output logic [DW-1:0]  lsu_w_data,
  output logic [2:0]     lsu_mode,
  input  wire logic [DW-1:0] lsu_r_data
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // Counter value at which the lsu read data is valid; unused when RD_LAT = 0.
  localparam logic [1:0] LAST_WAIT = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;

  state_t        state_q, state_d;
  logic          rr_last_q, rr_last_d;   // master granted most recently
  logic          win_q, win_d;           // master owning the current access
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [2:0]    mode_q, mode_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [DW-1:0] cap_q, cap_d;           // read data captured from the lsu
  logic [DW-1:0] rdata0_q, rdata0_d;     // last data returned to master 0
  logic [DW-1:0] rdata1_q, rdata1_d;     // last data returned to master 1

  logic          pick_m1;
  logic          in_issue;
  logic          in_resp;

  // A lone requester wins; on a tie the master that did not win last time goes.
  assign pick_m1  = (m0.req && m1.req) ? ~rr_last_q : m1.req;
  assign in_issue = (state_q == S_ISSUE);
  assign in_resp  = (state_q == S_RESP);

  // Next-state, arbitration and data capture.
  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    win_d     = win_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    cap_d     = cap_q;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;

    case (state_q)
      S_IDLE: begin
        if (m0.req || m1.req) begin
          win_d     = pick_m1;
          rr_last_d = pick_m1;
          we_d      = pick_m1 ? m1.we    : m0.we;
          addr_d    = pick_m1 ? m1.addr  : m0.addr;
          wdata_d   = pick_m1 ? m1.wdata : m0.wdata;
          mode_d    = pick_m1 ? m1.mode  : m0.mode;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (we_q) begin
          state_d = S_IDLE;
        end else if (RD_LAT == 0) begin
          cap_d   = lsu_r_data;
          state_d = S_RESP;
        end else begin
          cnt_d   = 2'd0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == LAST_WAIT) begin
          cap_d   = lsu_r_data;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      S_RESP: begin
        if (win_q) begin
          rdata1_d = cap_q;
        end else begin
          rdata0_d = cap_q;
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and payload registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rr_last_q <= 1'b1;
      win_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      mode_q    <= 3'd0;
      cnt_q     <= 2'd0;
      cap_q     <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      win_q     <= win_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      mode_q    <= mode_d;
      cnt_q     <= cnt_d;
      cap_q     <= cap_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  // The lsu bus comes straight from the payload registers, so it only moves
  // when a new access is accepted and stays put while idle.
  assign lsu_w_en   = in_issue && we_q;
  assign lsu_addr   = addr_q;
  assign lsu_w_data = wdata_q;
  assign lsu_mode   = mode_q;

  // Grant and valid pulses go to the owner of the current access only.
  assign m0.gnt    = in_issue && !win_q;
  assign m1.gnt    = in_issue &&  win_q;
  assign m0.rvalid = in_resp  && !win_q;
  assign m1.rvalid = in_resp  &&  win_q;

  // Fresh data is presented alongside rvalid; otherwise the last value holds.
  assign m0.rdata = (in_resp && !win_q) ? cap_q : rdata0_q;
  assign m1.rdata = (in_resp &&  win_q) ? cap_q : rdata1_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_arbiter
// Description : Scoreboard bench for lsu_arbiter. Three arbiters with read
//               latencies 1, 0 and 3 sit in front of simple lsu models; a
//               monitor checks every grant and read response.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_arbiter;
  localparam int          AW        = 16;
  localparam int          DW        = 32;
  localparam logic [15:0] SW_ADDR   = 16'h7000;
  localparam logic [15:0] LEDR_ADDR = 16'h7010;
  localparam logic [31:0] SW_VAL    = 32'h12345678;
  localparam logic [2:0]  MODE_W    = 3'b010;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Master-side stimulus, indexed [instance][master].
  logic [2:0][1:0]         drv_req   = '0;
  logic [2:0][1:0]         drv_we    = '0;
  logic [2:0][1:0][AW-1:0] drv_addr  = '0;
  logic [2:0][1:0][DW-1:0] drv_wdata = '0;
  logic [2:0][1:0][2:0]    drv_mode  = '0;

  // Observed DUT outputs.
  logic [2:0][1:0]         mon_gnt;
  logic [2:0][1:0]         mon_rvalid;
  logic [2:0][1:0][DW-1:0] mon_rdata;
  logic [2:0]              mon_wen;
  logic [2:0][AW-1:0]      mon_addr;
  logic [2:0][DW-1:0]      mon_wdata;
  logic [2:0][2:0]         mon_mode;

  for (genvar gi = 0; gi < 3; gi++) begin : g_inst
    localparam int LAT  = (gi == 0) ? 1 : ((gi == 1) ? 0 : 3);
    localparam int PIDX = (LAT == 0) ? 0 : LAT - 1;

    lsu_arbiter_if #(.AW(AW), .DW(DW)) m0_if ();
    lsu_arbiter_if #(.AW(AW), .DW(DW)) m1_if ();

    logic          l_wen;
    logic [AW-1:0] l_addr;
    logic [DW-1:0] l_wdata;
    logic [DW-1:0] l_rdata;
    logic [2:0]    l_mode;
    logic [DW-1:0] rd_now;
    logic [DW-1:0] mem  [512] = '{default: '0};
    logic [DW-1:0] pipe [3]   = '{default: '0};
    logic [DW-1:0] ledr = '0;

    assign m0_if.req   = drv_req[gi][0];
    assign m0_if.we    = drv_we[gi][0];
    assign m0_if.addr  = drv_addr[gi][0];
    assign m0_if.wdata = drv_wdata[gi][0];
    assign m0_if.mode  = drv_mode[gi][0];
    assign m1_if.req   = drv_req[gi][1];
    assign m1_if.we    = drv_we[gi][1];
    assign m1_if.addr  = drv_addr[gi][1];
    assign m1_if.wdata = drv_wdata[gi][1];
    assign m1_if.mode  = drv_mode[gi][1];

    assign mon_gnt[gi]      = {m1_if.gnt, m0_if.gnt};
    assign mon_rvalid[gi]   = {m1_if.rvalid, m0_if.rvalid};
    assign mon_rdata[gi][0] = m0_if.rdata;
    assign mon_rdata[gi][1] = m1_if.rdata;
    assign mon_wen[gi]      = l_wen;
    assign mon_addr[gi]     = l_addr;
    assign mon_wdata[gi]    = l_wdata;
    assign mon_mode[gi]     = l_mode;

    lsu_arbiter #(.AW(AW), .DW(DW), .RD_LAT(LAT)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .m0         (m0_if),
      .m1         (m1_if),
      .lsu_w_en   (l_wen),
      .lsu_addr   (l_addr),
      .lsu_w_data (l_wdata),
      .lsu_mode   (l_mode),
      .lsu_r_data (l_rdata)
    );

    // lsu model: DMEM plus SW (read-only) and LEDR registers, LAT-cycle reads.
    assign rd_now  = (l_addr == SW_ADDR)   ? SW_VAL :
                     (l_addr == LEDR_ADDR) ? ledr   : mem[l_addr[10:2]];
    assign l_rdata = (LAT == 0) ? rd_now : pipe[PIDX];

    always @(posedge clk) begin
      if (l_wen) begin
        if (l_addr == LEDR_ADDR) ledr <= l_wdata;
        else                     mem[l_addr[10:2]] <= l_wdata;
      end
      pipe[0] <= rd_now;
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
  end

  // Scoreboard state.
  typedef struct {
    string         name;
    logic [DW-1:0] act;
    logic [DW-1:0] exp;
  } chk_t;

  int            total = 0;
  int            bad   = 0;
  int            cyc   = 0;
  bit            pend    [3][2];
  int            due     [3][2];
  int            gnt_cnt [3][2];
  int            wen_cnt [3];
  logic [DW-1:0] exp_q   [3][2][$];
  chk_t          chk_q   [$];
  int            order_q [$];
  logic [DW-1:0] ref_mem [512] = '{default: '0};

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 0 : 3);
  endfunction

  task automatic post(input string n, input logic [DW-1:0] a, input logic [DW-1:0] e);
    chk_t c;
    c.name = n;
    c.act  = a;
    c.exp  = e;
    chk_q.push_back(c);
  endtask

  // Monitor: every comparison in the bench is counted here.
  initial begin : monitor
    chk_t c;
    logic [DW-1:0] e;
    for (int i = 0; i < 3; i++) begin
      wen_cnt[i] = 0;
      for (int m = 0; m < 2; m++) begin
        pend[i][m] = 1'b0; due[i][m] = 0; gnt_cnt[i][m] = 0;
      end
    end
    forever begin
      @(negedge clk);
      cyc++;
      while (chk_q.size() > 0) begin
        c = chk_q.pop_front();
        total++;
        if (c.act !== c.exp) begin
          bad++;
          $display("FAIL %s: got %h, want %h", c.name, c.act, c.exp);
        end
      end
      if (!rst_n) begin
        for (int i = 0; i < 3; i++)
          for (int m = 0; m < 2; m++) begin
            pend[i][m] = 1'b0;
            exp_q[i][m].delete();
          end
      end else begin
        for (int i = 0; i < 3; i++) begin
          if (mon_gnt[i] != 2'b00) begin
            total++;
            if (mon_gnt[i] == 2'b11) begin
              bad++;
              $display("FAIL both_gnt inst%0d: got %b, want one-hot", i, mon_gnt[i]);
            end
          end
          if (mon_wen[i]) begin
            wen_cnt[i]++;
            total++;
            if (mon_gnt[i] == 2'b00) begin
              bad++;
              $display("FAIL wen_without_gnt inst%0d: got gnt=%b, want a grant", i, mon_gnt[i]);
            end
          end
          for (int m = 0; m < 2; m++) begin
            if (mon_gnt[i][m]) begin
              gnt_cnt[i][m]++;
              if (!mon_wen[i]) begin
                pend[i][m] = 1'b1;
                due[i][m]  = cyc + lat_of(i) + 1;
              end
            end
            if (mon_rvalid[i][m]) begin
              total++;
              if (!pend[i][m]) begin
                bad++;
                $display("FAIL rvalid_unexpected inst%0d m%0d: got rvalid=1, want 0", i, m);
              end else begin
                pend[i][m] = 1'b0;
                if (cyc != due[i][m]) begin
                  bad++;
                  $display("FAIL rvalid_latency inst%0d m%0d: got cycle %0d, want %0d", i, m, cyc, due[i][m]);
                end
                total++;
                if (exp_q[i][m].size() == 0) begin
                  bad++;
                  $display("FAIL rdata inst%0d m%0d: got %h, want nothing queued", i, m, mon_rdata[i][m]);
                end else begin
                  e = exp_q[i][m].pop_front();
                  if (mon_rdata[i][m] !== e) begin
                    bad++;
                    $display("FAIL rdata inst%0d m%0d: got %h, want %h", i, m, mon_rdata[i][m], e);
                  end
                end
              end
            end else if (pend[i][m] && cyc > due[i][m]) begin
              total++;
              bad++;
              pend[i][m] = 1'b0;
              $display("FAIL rvalid_missing inst%0d m%0d: got none, want rvalid at cycle %0d", i, m, due[i][m]);
            end
          end
        end
      end
    end
  end

  // Issue one access and hold it until granted. Returns the grant cycle.
  task automatic access(input int i, input int m, input logic we,
                        input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [2:0] md, input logic [DW-1:0] expv,
                        output int gcyc);
    int n;
    drv_we[i][m]    = we;
    drv_addr[i][m]  = a;
    drv_wdata[i][m] = d;
    drv_mode[i][m]  = md;
    drv_req[i][m]   = 1'b1;
    if (i == 0 && we && a < 16'h0800) ref_mem[a[10:2]] = d;
    if (!we) exp_q[i][m].push_back(expv);
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (mon_gnt[i][m]) break;
    end
    if (n == 100) begin
      $display("FAIL gnt_timeout inst%0d m%0d: got no gnt, want gnt within 100 cycles", i, m);
      $fatal(1, "grant timeout");
    end
    post("lsu_addr", DW'(mon_addr[i]), DW'(a));
    post("lsu_mode", DW'(mon_mode[i]), DW'(md));
    if (we) post("lsu_w_data", mon_wdata[i], d);
    if (i == 0) order_q.push_back(m);
    #1;
    gcyc = cyc;
    @(posedge clk);
    #1;
    drv_req[i][m] = 1'b0;
  endtask

  // Random traffic for one master of instance 0, confined to its own half of DMEM.
  task automatic rand_master(input int m, input int n);
    int          idx;
    int          g;
    logic        we;
    logic [31:0] d;
    logic [2:0]  md;
    for (int k = 0; k < n; k++) begin
      idx = m * 256 + int'($urandom_range(0, 255));
      we  = 1'($urandom_range(0, 1));
      d   = $urandom;
      md  = 3'($urandom_range(0, 4));
      access(0, m, we, 16'(idx * 4), d, md, we ? 32'h0 : ref_mem[idx], g);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin : stim
    int g0, g1, s, wen0, gc0, n, outstanding;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      post("rst_ctrl", DW'({mon_gnt[i], mon_rvalid[i], mon_wen[i]}), 32'h0);
      post("rst_bus", DW'(mon_addr[i]) | mon_wdata[i] | DW'(mon_mode[i]), 32'h0);
      post("rst_rdata", mon_rdata[i][0] | mon_rdata[i][1], 32'h0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Simultaneous reads after reset: m0 first, then strict alternation.
    order_q.delete();
    fork
      begin
        access(0, 0, 1'b0, 16'h0020, 32'h0, MODE_W, ref_mem[8], g0);
        access(0, 0, 1'b0, 16'h0024, 32'h0, MODE_W, ref_mem[9], g0);
      end
      begin
        access(0, 1, 1'b0, 16'h0420, 32'h0, MODE_W, ref_mem[264], g1);
        access(0, 1, 1'b0, 16'h0424, 32'h0, MODE_W, ref_mem[265], g1);
      end
    join
    post("order_len", DW'(order_q.size()), 32'd4);
    for (int k = 0; k < 4; k++) post("order", DW'(order_q[k]), DW'(k % 2));

    // Single write then read-back through master 0.
    wen0 = wen_cnt[0];
    gc0  = gnt_cnt[0][0];
    access(0, 0, 1'b1, 16'h0010, 32'hDEADBEEF, MODE_W, 32'h0, g0);
    repeat (2) @(posedge clk);
    #1;
    post("wen_pulses", DW'(wen_cnt[0] - wen0), 32'd1);
    post("m0_gnt_pulses", DW'(gnt_cnt[0][0] - gc0), 32'd1);
    access(0, 0, 1'b0, 16'h0010, 32'h0, MODE_W, 32'hDEADBEEF, g0);
    repeat (4) @(posedge clk);
    #1;
    post("m0_rdata_hold", mon_rdata[0][0], 32'hDEADBEEF);

    // Asynchronous reset while a read is waiting on the lsu.
    access(0, 0, 1'b0, 16'h0010, 32'h0, MODE_W, 32'hDEADBEEF, g0);
    #1;
    rst_n = 1'b0;
    #1;
    post("arst_ctrl", DW'({mon_gnt[0], mon_rvalid[0], mon_wen[0]}), 32'h0);
    post("arst_addr", DW'(mon_addr[0]), 32'h0);
    post("arst_rdata", mon_rdata[0][0], 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    access(0, 0, 1'b0, 16'h0010, 32'h0, MODE_W, 32'hDEADBEEF, g0);

    // LEDR write from m1 cutting into a continuous m0 read stream.
    fork
      begin
        for (int k = 0; k < 6; k++)
          access(0, 0, 1'b0, 16'(16'h0040 + k * 4), 32'h0, MODE_W, ref_mem[16 + k], g0);
      end
      begin
        repeat (2) begin
          @(posedge clk);
          #1;
        end
        s = cyc;
        access(0, 1, 1'b1, LEDR_ADDR, 32'h000000A5, MODE_W, 32'h0, g1);
        post("m1_wait_bounded", DW'(g1 - s <= 6), 32'd1);
      end
    join
    repeat (2) @(posedge clk);
    #1;
    post("ledr", g_inst[0].ledr, 32'h000000A5);

    // SW reads across read latencies 1, 0 and 3, plus DMEM round trips.
    access(0, 0, 1'b0, SW_ADDR, 32'h0, MODE_W, SW_VAL, g0);
    access(1, 0, 1'b0, SW_ADDR, 32'h0, MODE_W, SW_VAL, g0);
    access(2, 1, 1'b0, SW_ADDR, 32'h0, MODE_W, SW_VAL, g1);
    access(1, 1, 1'b1, 16'h0030, 32'h55AA00FF, MODE_W, 32'h0, g1);
    access(1, 1, 1'b0, 16'h0030, 32'h0, MODE_W, 32'h55AA00FF, g1);
    access(2, 0, 1'b1, 16'h0034, 32'hCAFEF00D, MODE_W, 32'h0, g0);
    access(2, 0, 1'b0, 16'h0034, 32'h0, MODE_W, 32'hCAFEF00D, g0);

    // Random mixed traffic from both masters.
    fork
      rand_master(0, 1000);
      rand_master(1, 1000);
    join

    // Let outstanding reads finish, then confirm nothing is left over.
    for (n = 0; n < 50; n++) begin
      outstanding = 0;
      for (int i = 0; i < 3; i++)
        for (int m = 0; m < 2; m++)
          outstanding += exp_q[i][m].size() + int'(pend[i][m]);
      if (outstanding == 0) break;
      @(posedge clk);
      #1;
    end
    post("drain", DW'(outstanding), 32'h0);
    repeat (2) @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
